line_strobe_decoder_38: RTL and testbench
=========================================

Name: line_strobe_decoder_38

Overview:
- Sequential counterpart to the 8-to-3 priority encoder.
- Accepts the 4-bit encoder code, {valid, idx[2:0]}, through a valid/ready handshake.
- Drives the matching one-hot line of an 8-bit output for a programmable number of cycles, then an optional gap.
- Used to turn encoded requests back into timed per-line strobes, e.g. LED and enable lines on the FPGA board.

Parameters:
- HOLD_CYCLES, 4: cycles the one-hot line stays asserted; legal range >=1.
- GAP_CYCLES, 1: idle cycles after each strobe before the next accept; legal range >=0.
- CNT_W, 8: counter width; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- code_in  input  4  [3] = code valid (some request present), [2:0] = line index
- code_valid  input  1  code_in is offered
- code_ready  output  1  block can accept a code this cycle
- y  output  8  one-hot strobe lines, registered
- busy  output  1  high in DRIVE or GAP
- done  output  1  one-cycle pulse on the last cycle y is non-zero
- null_pulse  output  1  one-cycle pulse when a code with code_in[3]=0 is accepted

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values (after any rst edge): y=0, busy=0, done=0, null_pulse=0, state=IDLE, counter=0.
- code_ready is 0 whenever rst=1.
- FSM states: IDLE, DRIVE, GAP.
- code_ready = (state==IDLE) && !rst. This is combinational from the state register.
- Accept occurs at a rising edge when code_valid && code_ready. code_in is sampled only at accept; later changes are ignored.
- IDLE, accept with code_in[3]=1:
  - Next cycle: y = 1 << code_in[2:0], busy=1, state=DRIVE, counter=HOLD_CYCLES-1.
  - Latency is 1 cycle from the accept edge to y valid.
- IDLE, accept with code_in[3]=0:
  - null_pulse=1 for the next cycle; y stays 0; state stays IDLE; code_ready stays 1.
- DRIVE:
  - y holds its value; the counter decrements each cycle.
  - done=1 in the cycle where counter==0 (the last cycle y is high).
  - At that edge: y becomes 0. If GAP_CYCLES==0, go to IDLE; otherwise go to GAP with counter=GAP_CYCLES-1.
- GAP:
  - y=0, busy=1; the counter decrements.
  - At counter==0, go to IDLE; busy=0 from the IDLE cycle onward.
- y is exactly one-hot or all-zero at all times. Never more than one bit is set.
- Throughput: one strobe per HOLD_CYCLES + GAP_CYCLES + 1 cycles. The +1 is the IDLE accept cycle.
- code_valid held high continuously: a new accept occurs on each IDLE cycle. No codes are queued.
- Reset mid-DRIVE or mid-GAP:
  - y=0 and state=IDLE at the rst edge.
  - No done pulse is issued; the in-flight strobe is discarded.
- Counter wrap: the counter never wraps, because it is loaded on entry and stops at 0.
- HOLD_CYCLES > 2^CNT_W is illegal and must be flagged by a simulation-time check.

Decomposition:
- Shared include file holds:
  - localparam state encodings: IDLE=2'd0, DRIVE=2'd1, GAP=2'd2
  - CODE_VLD_BIT=3
  - IDX_W=3
- These constants match the encoder's output format, so both blocks use the same file.
- One sub-module: dec_38_onehot. It is the combinational 3-to-8 one-hot decoder, instantiated once and feeding the y register.
- FSM and counter stay in the top module.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=1 unless stated):
- Reset: rst=1 for 3 cycles with code_valid=1 -> y=8'h00, code_ready=0, busy=0 throughout. Cycle after rst falls -> code_ready=1.
- Single code: code_in=4'b1110 accepted at cycle 0 -> y=8'b0100_0000 in cycles 1-4; done=1 in cycle 4 only; cycle 5 y=0, busy=1; cycle 6 code_ready=1, busy=0.
- Full sweep: codes 4'b1000..4'b1111 back-to-back, code_valid always high -> y = 8'h01, 02, 04, 08, 10, 20, 40, 80 in order. Each held exactly 4 cycles; accepts spaced 6 cycles apart; y never has two bits set.
- Null code: code_in=4'b0101 accepted -> null_pulse=1 for one cycle, y stays 8'h00, code_ready stays 1. Next code 4'b1001 is accepted the following cycle -> y=8'h02.
- Ignored input and mid-operation reset: accept 4'b1011 (y=8'h08); toggle code_in during DRIVE -> y unchanged. Assert rst in cycle 2 of DRIVE -> y=0 at that edge, no done, code_ready=1 after rst falls.
- Corner parameters HOLD_CYCLES=1, GAP_CYCLES=0: accept 4'b1111 -> y=8'h80 for exactly 1 cycle with done=1 in the same cycle. IDLE next cycle; with code_valid held, y is high 1 cycle of every 2.

Source files
------------

// File: rtl/line_strobe_decoder_38_pkg.sv
// Shared constants for the 8-to-3 encoder / 3-to-8 strobe decoder pair.
// The code format {valid, idx[2:0]} is defined here so that both blocks
// agree on where the valid bit sits and how wide the line index is.
package line_strobe_decoder_38_pkg;

   localparam int IDX_W        = 3;
   localparam int LINES        = 1 << IDX_W;
   localparam int CODE_VLD_BIT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/line_strobe_decoder_38_dec_38_onehot.sv
// Combinational 3-to-8 one-hot decoder.
// Ports:
//   idx    - line index
//   onehot - exactly one bit set, at position idx
module dec_38_onehot
   import line_strobe_decoder_38_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [LINES-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/line_strobe_decoder_38.sv
// Timed one-hot strobe generator driven by {valid, idx} encoder codes.
// An accepted valid code raises line idx of y for HOLD_CYCLES cycles,
// then the block idles GAP_CYCLES cycles before accepting again. A code
// with the valid bit clear is consumed and answered with null_pulse.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   code_in     - {valid, idx[2:0]}, sampled only at accept
//   code_valid  - code_in offered
//   code_ready  - block can accept this cycle (IDLE and not in reset)
//   y           - registered one-hot strobe lines
//   busy        - strobe or gap in progress
//   done        - pulse on the last cycle y is non-zero
//   null_pulse  - pulse after accepting a code whose valid bit is clear
module line_strobe_decoder_38
   import line_strobe_decoder_38_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic [LINES-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             null_pulse
);

   // Counters are loaded with N-1 on entry and leave the state at 0, so
   // they never wrap.
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W)) begin : g_bad_hold
      $error("line_strobe_decoder_38: HOLD_CYCLES out of range for CNT_W");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > (2 ** CNT_W)) begin : g_bad_gap
      $error("line_strobe_decoder_38: GAP_CYCLES out of range for CNT_W");
   end

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [LINES-1:0] y_n, line;
   logic             null_n;
   logic             accept;
   logic             cnt_zero;

   dec_38_onehot u_dec (
      .idx    (code_in[IDX_W-1:0]),
      .onehot (line)
   );

   assign code_ready = (state_q == IDLE) && !rst;
   assign accept     = code_valid && code_ready;
   assign cnt_zero   = (cnt_q == '0);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DRIVE) && cnt_zero;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      y_n     = y;
      null_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (code_in[CODE_VLD_BIT]) begin
                  state_n = DRIVE;
                  cnt_n   = HOLD_LD;
                  y_n     = line;
               end else begin
                  null_n  = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (cnt_zero) begin
               y_n = '0;
               if (GAP_CYCLES == 0) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  state_n = GAP;
                  cnt_n   = GAP_LD;
               end
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            y_n     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         y          <= '0;
         null_pulse <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         y          <= y_n;
         null_pulse <= null_n;
      end
   end

endmodule

// File: tb/tb_line_strobe_decoder_38.sv
// Bench for line_strobe_decoder_38: dut 0 uses HOLD=4/GAP=1, dut 1 uses
// HOLD=1/GAP=0. A timeline model (age since accept) predicts every output.
module tb_line_strobe_decoder_38;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i  [2];
   logic       cv_i   [2];
   logic [3:0] ci_i   [2];
   logic       rdy_o  [2];
   logic [7:0] y_o    [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       nul_o  [2];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   line_strobe_decoder_38 #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst_i[0]), .code_in(ci_i[0]), .code_valid(cv_i[0]),
      .code_ready(rdy_o[0]), .y(y_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .null_pulse(nul_o[0]));

   line_strobe_decoder_38 #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_c (
      .clk(clk), .rst(rst_i[1]), .code_in(ci_i[1]), .code_valid(cv_i[1]),
      .code_ready(rdy_o[1]), .y(y_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .null_pulse(nul_o[1]));

   // Reference model: an accepted strobe occupies ages 1..H (line high)
   // and H+1..H+G (gap); anything beyond is idle.
   int hp [2] = '{4, 1};
   int gp [2] = '{1, 0};
   bit m_act [2] = '{0, 0};
   int m_age [2] = '{0, 0};
   int m_idx [2] = '{0, 0};
   bit m_nul [2] = '{0, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] m_y(input int d);
      logic [7:0] one;
      one = 8'd1;
      if (m_act[d] && m_age[d] <= hp[d]) return one << m_idx[d];
      return 8'h00;
   endfunction

   task automatic model_edge(input int d);
      m_nul[d] = 1'b0;
      if (rst_i[d]) begin
         m_act[d] = 1'b0;
      end else if (!m_act[d]) begin
         if (cv_i[d]) begin
            if (ci_i[d][3]) begin
               m_act[d] = 1'b1;
               m_age[d] = 1;
               m_idx[d] = int'(ci_i[d][2:0]);
            end else begin
               m_nul[d] = 1'b1;
            end
         end
      end else begin
         m_age[d]++;
         if (m_age[d] > hp[d] + gp[d]) m_act[d] = 1'b0;
      end
   endtask

   task automatic model_chk(input int d);
      string p;
      p = (d == 0) ? "m0" : "m1";
      chk({p, " y"},      32'(y_o[d]),    32'(m_y(d)));
      chk({p, " busy"},   32'(busy_o[d]), 32'(m_act[d]));
      chk({p, " done"},   32'(done_o[d]), 32'(m_act[d] && m_age[d] == hp[d]));
      chk({p, " ready"},  32'(rdy_o[d]),  32'(!rst_i[d] && !m_act[d]));
      chk({p, " null"},   32'(nul_o[d]),  32'(m_nul[d]));
      chk({p, " onehot"}, 32'($countones(y_o[d]) <= 1), 32'd1);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      #1;
      model_chk(0);
      model_chk(1);
   endtask

   typedef struct {
      logic       rst;
      logic       cv;
      logic [3:0] code;
      logic [7:0] y;
      logic       busy;
      logic       done;
      logic       rdy;
      logic       nul;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int highs;
      logic [7:0] one;
      one = 8'd1;

      // reset with code_valid high, single code 1110, null code then 1001
      tbl.push_back('{1'b1, 1'b1, 4'b1110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 4'b1110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 4'b1110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b1110, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'b1110, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b1001, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

      rst_i[1] = 1'b1; cv_i[1] = 1'b0; ci_i[1] = 4'h0;
      foreach (tbl[i]) begin
         rst_i[0] = tbl[i].rst;
         cv_i[0]  = tbl[i].cv;
         ci_i[0]  = tbl[i].code;
         step();
         chk($sformatf("tbl%0d y", i),     32'(y_o[0]),    32'(tbl[i].y));
         chk($sformatf("tbl%0d busy", i),  32'(busy_o[0]), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d done", i),  32'(done_o[0]), 32'(tbl[i].done));
         chk($sformatf("tbl%0d ready", i), 32'(rdy_o[0]),  32'(tbl[i].rdy));
         chk($sformatf("tbl%0d null", i),  32'(nul_o[0]),  32'(tbl[i].nul));
      end
      rst_i[1] = 1'b0;

      // full sweep, code_valid held high: each line 4 cycles, 6-cycle spacing
      cv_i[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("sweep%0d ready", i), 32'(rdy_o[0]), 32'd1);
         ci_i[0] = 4'b1000 | 4'(i);
         for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("sweep%0d.%0d y", i, k), 32'(y_o[0]),
                32'((k <= 4) ? (one << i) : 8'h00));
         end
      end
      cv_i[0] = 1'b0;

      // input changes during DRIVE are ignored; reset mid-DRIVE drops it
      cv_i[0] = 1'b1; ci_i[0] = 4'b1011;
      step();
      chk("ign y1", 32'(y_o[0]), 32'h08);
      cv_i[0] = 1'b0; ci_i[0] = 4'b1110;
      step();
      chk("ign y2", 32'(y_o[0]), 32'h08);
      ci_i[0] = 4'b0001; rst_i[0] = 1'b1;
      step();
      chk("mrst y",    32'(y_o[0]),    32'h00);
      chk("mrst done", 32'(done_o[0]), 32'd0);
      rst_i[0] = 1'b0;
      step();
      chk("mrst ready", 32'(rdy_o[0]),  32'd1);
      chk("mrst busy",  32'(busy_o[0]), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("mrst nodone", 32'(done_o[0] | (|y_o[0])), 32'd0);
      end

      // HOLD=1, GAP=0: line high one cycle of every two, done same cycle
      cv_i[1] = 1'b1; ci_i[1] = 4'b1111;
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (y_o[1] == 8'h80) highs++;
         if (k % 2 == 0) begin
            chk("c y hi",  32'(y_o[1]),    32'h80);
            chk("c done",  32'(done_o[1]), 32'd1);
         end else begin
            chk("c y lo",  32'(y_o[1]),    32'h00);
            chk("c ready", 32'(rdy_o[1]),  32'd1);
         end
      end
      chk("c highs", 32'(highs), 32'd5);
      cv_i[1] = 1'b0;

      // random traffic on both instances against the model
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) begin
            rst_i[d] = ($urandom_range(0, 39) == 0);
            cv_i[d]  = ($urandom_range(0, 9) < 7);
            ci_i[d]  = 4'($urandom);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
